// File: rtl/icache_ctrl.sv
// Sequencer for a 4-set, 64 B-line, direct-mapped instruction cache array:
// tag lookup, 16-beat line fill on miss with replay, and full-cache flush.
module icache_ctrl #(
    parameter int unsigned TAG_W = 24,
    parameter int unsigned BEATS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_va,
    input  logic [TAG_W-1:0] fetch_ptag,
    output logic             fetch_rdy,
    output logic             fetch_valid,
    output logic [31:0]      fetch_data,
    output logic             fetch_fault,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             c_read_enable,
    output logic             c_write_enable,
    output logic             c_invalidate,
    output logic [31:0]      c_va,
    output logic [TAG_W-1:0] c_ptag,
    output logic [31:0]      c_write_data,
    output logic             c_valid_data,
    output logic             c_dirty_data,
    input  logic [511:0]     c_line,
    input  logic [TAG_W-1:0] c_tag,
    input  logic [1:0]       c_meta,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata
);
    localparam int unsigned BeatW = $clog2(BEATS);

    typedef enum logic [2:0] {
        StIdle, StLookup, StMissReq, StFill, StReplay, StFlush
    } state_t;

    state_t             state_q;
    logic [31:0]        va_q;
    logic [TAG_W-1:0]   ptag_q;
    logic [BeatW-1:0]   beat_q;
    logic [2:0]         flush_idx_q;

    logic [5:0]         offset;
    logic               hit;
    logic [31:0]        line_word;
    logic               unused_meta;

    assign offset       = va_q[5:0];
    assign hit          = c_meta[1] && (c_tag == ptag_q);
    assign line_word    = c_line[{offset, 3'b000} +: 32];
    assign fetch_rdy    = (state_q == StIdle);
    assign c_dirty_data = 1'b0;
    assign unused_meta  = c_meta[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            va_q           <= '0;
            ptag_q         <= '0;
            beat_q         <= '0;
            flush_idx_q    <= '0;
            fetch_valid    <= 1'b0;
            fetch_data     <= '0;
            fetch_fault    <= 1'b0;
            flush_done     <= 1'b0;
            c_read_enable  <= 1'b0;
            c_write_enable <= 1'b0;
            c_invalidate   <= 1'b0;
            c_va           <= '0;
            c_ptag         <= '0;
            c_write_data   <= '0;
            c_valid_data   <= 1'b0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
        end else begin
            // Strobes and pulses are single-cycle unless re-asserted below.
            c_read_enable  <= 1'b0;
            c_write_enable <= 1'b0;
            fetch_valid    <= 1'b0;
            fetch_fault    <= 1'b0;
            flush_done     <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (flush_req) begin
                        c_invalidate   <= 1'b1;
                        c_write_enable <= 1'b1;
                        c_valid_data   <= 1'b0;
                        c_va           <= '0;
                        flush_idx_q    <= 3'd1;
                        state_q        <= StFlush;
                    end else if (fetch_req) begin
                        va_q          <= fetch_va;
                        ptag_q        <= fetch_ptag;
                        c_read_enable <= 1'b1;
                        c_va          <= fetch_va;
                        state_q       <= StLookup;
                    end
                end
                StLookup: begin
                    if (offset > 6'd60) begin
                        fetch_fault <= 1'b1;
                        state_q     <= StIdle;
                    end else if (hit) begin
                        fetch_valid <= 1'b1;
                        fetch_data  <= line_word;
                        state_q     <= StIdle;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= 32'({ptag_q, va_q[7:6], 6'b0});
                        state_q  <= StMissReq;
                    end
                end
                StMissReq: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        beat_q  <= '0;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (mem_rvalid) begin
                        c_write_enable <= 1'b1;
                        c_va           <= {va_q[31:6], 6'(beat_q) << 2};
                        c_write_data   <= mem_rdata;
                        c_ptag         <= ptag_q;
                        // Only the final beat marks the line valid.
                        c_valid_data   <= (beat_q == BeatW'(BEATS - 1));
                        if (beat_q == BeatW'(BEATS - 1)) begin
                            beat_q  <= '0;
                            state_q <= StReplay;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StReplay: begin
                    c_read_enable <= 1'b1;
                    c_va          <= va_q;
                    state_q       <= StLookup;
                end
                StFlush: begin
                    if (flush_idx_q < 3'd4) begin
                        c_write_enable <= 1'b1;
                        c_valid_data   <= 1'b0;
                        c_va           <= {24'h0, flush_idx_q[1:0], 6'h0};
                        flush_idx_q    <= flush_idx_q + 3'd1;
                    end else if (flush_idx_q == 3'd4) begin
                        flush_done  <= 1'b1;
                        flush_idx_q <= 3'd5;
                    end else begin
                        flush_idx_q  <= '0;
                        c_invalidate <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a behavioural cache array attached.
module tb_icache_ctrl;
    localparam int unsigned TAG_W = 24;
    localparam int unsigned BEATS = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             fetch_req;
    logic [31:0]      fetch_va;
    logic [TAG_W-1:0] fetch_ptag;
    logic             fetch_rdy;
    logic             fetch_valid;
    logic [31:0]      fetch_data;
    logic             fetch_fault;
    logic             flush_req;
    logic             flush_done;
    logic             c_read_enable;
    logic             c_write_enable;
    logic             c_invalidate;
    logic [31:0]      c_va;
    logic [TAG_W-1:0] c_ptag;
    logic [31:0]      c_write_data;
    logic             c_valid_data;
    logic             c_dirty_data;
    logic [511:0]     c_line;
    logic [TAG_W-1:0] c_tag;
    logic [1:0]       c_meta;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_ctrl #(.TAG_W(TAG_W), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_va(fetch_va), .fetch_ptag(fetch_ptag),
        .fetch_rdy(fetch_rdy), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .fetch_fault(fetch_fault), .flush_req(flush_req), .flush_done(flush_done),
        .c_read_enable(c_read_enable), .c_write_enable(c_write_enable),
        .c_invalidate(c_invalidate), .c_va(c_va), .c_ptag(c_ptag),
        .c_write_data(c_write_data), .c_valid_data(c_valid_data),
        .c_dirty_data(c_dirty_data), .c_line(c_line), .c_tag(c_tag), .c_meta(c_meta),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Behavioural array: combinational read, write on the clock edge.
    logic [511:0]     arr_line [4];
    logic [TAG_W-1:0] arr_tag  [4];
    logic [3:0]       arr_valid = '0;

    assign c_line = arr_line[c_va[7:6]];
    assign c_tag  = arr_tag[c_va[7:6]];
    assign c_meta = {arr_valid[c_va[7:6]], 1'b0};

    always @(posedge clk) begin
        if (c_write_enable) begin
            if (c_invalidate) begin
                arr_valid[c_va[7:6]] <= 1'b0;
            end else begin
                arr_line[c_va[7:6]][{c_va[5:0], 3'b000} +: 32] <= c_write_data;
                arr_tag[c_va[7:6]]   <= c_ptag;
                arr_valid[c_va[7:6]] <= c_valid_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_go(input logic [31:0] va, input logic [TAG_W-1:0] ptag);
        check("rdy_before_req", fetch_rdy, 1);
        fetch_req  = 1'b1;
        fetch_va   = va;
        fetch_ptag = ptag;
        step;
        fetch_req  = 1'b0;
        check("lookup_oe", c_read_enable, 1);
        check("lookup_va", c_va, va);
        check("lookup_rdy", fetch_rdy, 0);
    endtask

    task automatic expect_hit(input logic [31:0] data);
        check("hit_valid", fetch_valid, 1);
        check("hit_data", fetch_data, data);
        check("hit_no_fault", fetch_fault, 0);
        check("hit_no_memreq", mem_req, 0);
    endtask

    // Serves a miss: stray rvalid before grant, grant, then nbeats beats.
    task automatic fill(input logic [31:0] exp_addr, input logic [31:0] base,
                        input int nbeats, input int gap);
        check("miss_req", mem_req, 1);
        check("miss_addr", mem_addr, exp_addr);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step;
        mem_rvalid = 1'b0;
        check("stray_rvalid_no_we", c_write_enable, 0);
        check("req_held", mem_req, 1);
        check("addr_stable", mem_addr, exp_addr);
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        check("req_drop_after_gnt", mem_req, 0);
        for (int n = 0; n < nbeats; n++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 32'(n);
            step;
            mem_rvalid = 1'b0;
            check("fill_we", c_write_enable, 1);
            check("fill_off", c_va[7:0], exp_addr[7:0] + 8'(n * 4));
            check("fill_data", c_write_data, base + 32'(n));
            check("fill_valid", c_valid_data, (n == BEATS - 1) ? 1 : 0);
            check("fill_ptag", c_ptag, exp_addr[31:8]);
            if (n < nbeats - 1) begin
                for (int g = 0; g < gap; g++) begin
                    step;
                    check("gap_no_we", c_write_enable, 0);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        fetch_req  = 1'b0;
        fetch_va   = '0;
        fetch_ptag = '0;
        flush_req  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_rdy", fetch_rdy, 1);
        check("rst_valid", fetch_valid, 0);
        check("rst_we", c_write_enable, 0);
        check("rst_oe", c_read_enable, 0);
        check("rst_inv", c_invalidate, 0);
        check("rst_memreq", mem_req, 0);
        check("rst_dirty", c_dirty_data, 0);
        step;
        step;
        reset = 1'b0;
        step;

        // Flush wins over a simultaneous fetch.
        flush_req  = 1'b1;
        fetch_req  = 1'b1;
        fetch_va   = 32'h44;
        fetch_ptag = 24'hABCDEF;
        step;
        flush_req = 1'b0;
        fetch_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush_we", c_write_enable, 1);
            check("flush_idx", c_va[7:6], i);
            check("flush_vd", c_valid_data, 0);
            check("flush_inv", c_invalidate, 1);
            check("flush_rdy", fetch_rdy, 0);
            check("flush_done_early", flush_done, 0);
            step;
        end
        check("flush_done", flush_done, 1);
        check("flush_done_we", c_write_enable, 0);
        check("flush_done_rdy", fetch_rdy, 0);
        step;
        check("flush_done_pulse", flush_done, 0);
        check("post_flush_rdy", fetch_rdy, 1);
        check("post_flush_inv", c_invalidate, 0);
        check("flush_fetch_dropped", c_read_enable, 0);

        // Cold miss, fill with gaps, replay hit.
        fetch_go(32'h44, 24'hABCDEF);
        step;
        check("cold_no_valid", fetch_valid, 0);
        fill(32'hABCDEF40, 32'h1000, 16, 2);
        step;
        check("replay_oe", c_read_enable, 1);
        check("replay_va", c_va, 32'h44);
        step;
        expect_hit(32'h1001);

        // Warm hits: 2-cycle latency, boundary offset 60, unaligned offset.
        fetch_go(32'h44, 24'hABCDEF);
        step;
        expect_hit(32'h1001);
        fetch_go(32'h7C, 24'hABCDEF);
        step;
        expect_hit(32'h100F);
        fetch_go(32'h45, 24'hABCDEF);
        step;
        expect_hit(32'h0200_0010);

        // Tag mismatch refills, then the old tag misses again.
        fetch_go(32'h44, 24'h123456);
        step;
        fill(32'h1234_5640, 32'h2000, 16, 0);
        step;
        step;
        expect_hit(32'h2001);
        fetch_go(32'h48, 24'hABCDEF);
        step;
        fill(32'hABCDEF40, 32'h1000, 16, 1);
        step;
        step;
        expect_hit(32'h1002);

        // Offset past 60 faults even though the line hits.
        fetch_go(32'h7E, 24'hABCDEF);
        step;
        check("fault_pulse", fetch_fault, 1);
        check("fault_no_valid", fetch_valid, 0);
        check("fault_no_memreq", mem_req, 0);
        check("fault_rdy", fetch_rdy, 1);
        step;
        check("fault_one_cycle", fetch_fault, 0);
        check("fault_still_no_memreq", mem_req, 0);

        // Reset during beat 7 of a fill; line must stay invalid.
        fetch_go(32'h84, 24'hABCDEF);
        step;
        fill(32'hABCDEF80, 32'h3000, 8, 0);
        reset = 1'b1;
        #1;
        check("midfill_rst_we", c_write_enable, 0);
        check("midfill_rst_memreq", mem_req, 0);
        check("midfill_rst_va", c_va, 0);
        check("midfill_rst_wdata", c_write_data, 0);
        check("midfill_rst_rdy", fetch_rdy, 1);
        step;
        reset = 1'b0;
        step;
        fetch_go(32'h84, 24'hABCDEF);
        step;
        check("partial_line_miss", mem_req, 1);
        check("partial_line_no_hit", fetch_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Sequencer for the 4-set, 64-byte-line, direct-mapped instruction cache array: it owns every read, write and invalidate strobe on the array.
- Accepts fetch requests from the fetch stage (VA + physical tag from the TLB) and compares tags.
- On a hit, returns 32 bits of instruction data. On a miss, fetches the line from memory in 16 word beats, writes it into the array, then replays the lookup.
- Also sequences a full-cache flush.

Parameters:
- TAG_W, 24, physical tag width; equals PA[31:8].
- BEATS, 16, memory beats per line (64 B / 4 B).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request valid.
- fetch_va  in  32  fetch virtual address; [7:6] index, [5:0] offset.
- fetch_ptag  in  TAG_W  physical tag for fetch_va.
- fetch_rdy  out  1  controller can accept a request this cycle.
- fetch_valid  out  1  fetch_data valid (one-cycle pulse).
- fetch_data  out  32  line bytes offset..offset+3, byte at offset in [7:0].
- fetch_fault  out  1  pulse in place of fetch_valid when offset > 60.
- flush_req  in  1  invalidate all sets; sampled only in IDLE.
- flush_done  out  1  one-cycle pulse when the flush completes.
- c_read_enable  out  1  array OE.
- c_write_enable  out  1  array write strobe.
- c_invalidate  out  1  array invalidate.
- c_va  out  32  array address.
- c_ptag  out  TAG_W  tag to write.
- c_write_data  out  32  fill word.
- c_valid_data  out  1  valid bit to write.
- c_dirty_data  out  1  dirty bit to write; tied 0.
- c_line  in  512  array data_minibus.
- c_tag  in  TAG_W  array tag_minibus.
- c_meta  in  2  array {valid, dirty}.
- mem_req  out  1  line read request; held until mem_gnt.
- mem_addr  out  32  {ptag, index, 6'b0}.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  beat valid.
- mem_rdata  in  32  beat data; beats arrive in ascending address order.

Behaviour:
- States: IDLE, LOOKUP, MISS_REQ, FILL, REPLAY, FLUSH.
- Reset (async) forces IDLE, beat counter 0, and flush index 0. All outputs are 0 except fetch_rdy = 1.
- IDLE (fetch_rdy = 1):
  - If flush_req is high, go to FLUSH. Flush has priority over a simultaneous fetch_req, and that fetch_req is not accepted.
  - Else if fetch_req is high, latch va/ptag, assert c_read_enable with c_va = fetch_va, and go to LOOKUP.
- LOOKUP:
  - Hit is c_meta[1] && c_tag == latched ptag.
  - If offset > 60, pulse fetch_fault and go to IDLE, regardless of hit.
  - Else on hit, pulse fetch_valid with the fetch_data slice and go to IDLE. Hit latency is 2 cycles from request acceptance to fetch_valid.
  - Else go to MISS_REQ.
- MISS_REQ: hold mem_req high with a stable mem_addr. When mem_gnt is seen, deassert mem_req the next cycle and go to FILL with beat = 0.
- FILL, on each mem_rvalid:
  - Pulse c_write_enable for one cycle.
  - c_va = {va[31:8], index, beat*4}; c_write_data = mem_rdata; c_ptag = latched ptag.
  - c_valid_data = 1 only on beat 15, 0 on beats 0-14, so a partial line never reads as valid.
  - Increment beat. On beat 15 go to REPLAY.
  - Cycles without mem_rvalid hold state with no strobes.
- REPLAY: assert c_read_enable and go to LOOKUP. Replay must hit. A miss on replay (a tag-path fault) re-enters MISS_REQ with no special case.
- FLUSH:
  - For idx 0..3, one per cycle, pulse c_write_enable with c_va[7:6] = idx and c_valid_data = 0.
  - The cycle after idx 3, pulse flush_done and go to IDLE. Flush takes 5 cycles.
  - c_invalidate is held high through all of FLUSH.
- fetch_rdy is 0 in every state except IDLE. fetch_req while not ready is ignored; the requester must hold it.
- Reset mid-FILL abandons the line; set state is unspecified except that valid was never written as 1.
- Reset mid-MISS_REQ drops mem_req immediately.
- mem_rvalid outside FILL is ignored. Beat count wraps only via the state exit, never by modulo.
- Writes are always word-aligned (offset ≤ 60), so the array's unaligned_write is never raised by this block.

Test Plan:
- Reset, then flush_req in IDLE → c_write_enable pulses for idx 0,1,2,3 with c_valid_data = 0, then flush_done at cycle 5 with fetch_rdy = 0 throughout.
- Cold fetch va=0x0000_0044, ptag=0xABCDEF:
  - Miss → mem_req with mem_addr = 0xABCDEF40.
  - 16 beats of 0x1000+n, with 2-cycle gaps injected, → 16 writes at offsets 0..60, valid = 1 only on the last.
  - Replay hits → fetch_data = 0x1001.
- Repeat same fetch → fetch_valid 2 cycles after acceptance with 0x1001, and no mem_req.
- Same index, ptag=0x123456 → tag mismatch → miss refills the line, then the old ptag misses again.
- va offset 0x3E → fetch_fault pulse with no fetch_valid and no memory traffic.
- Assert reset at beat 7 of a fill → all outputs at reset values immediately. A following lookup of that line misses (valid = 0).
